// File: rtl/gf180mcu_osu_sc_gp9t3v3__dlymon_pkg.sv
// Shared state encoding and elaboration-time helpers for the inverter-chain delay monitor.
package gf180mcu_osu_sc_gp9t3v3__dlymon_pkg;

  localparam int MAX_TAPS = 1024;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESET = 3'd1,
    ST_FIRE   = 3'd2,
    ST_CAPT   = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  // Width able to hold a stage count of 0..ntaps inclusive.
  function automatic int calc_cw(input int ntaps);
    return $clog2(ntaps + 1);
  endfunction

  // Odd taps come back inverted from the chain; this mask restores them.
  function automatic logic [MAX_TAPS-1:0] alt_mask(input int ntaps);
    logic [MAX_TAPS-1:0] m;
    m = '0;
    for (int i = 1; i < MAX_TAPS; i += 2) begin
      if (i < ntaps) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp9t3v3__therm2bin.sv
// Leading-ones count of a thermometer code plus a flag for any 1 above the first 0.
// Purely combinational.
module gf180mcu_osu_sc_gp9t3v3__therm2bin
  import gf180mcu_osu_sc_gp9t3v3__dlymon_pkg::*;
#(
  parameter int NTAPS = 32,
  parameter int CW    = calc_cw(NTAPS)
) (
  input  logic [NTAPS-1:0] therm_i,
  output logic [CW-1:0]    code_o,
  output logic             bubble_o
);

  always_comb begin
    logic seen_zero;
    code_o    = CW'(NTAPS);
    bubble_o  = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      if (!therm_i[i] && !seen_zero) begin
        seen_zero = 1'b1;
        code_o    = CW'(i);
      end else if (therm_i[i] && seen_zero) begin
        bubble_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_osu_sc_gp9t3v3__dlymon.sv
// Delay monitor: launches an edge into the inverter chain, captures tap depth CAP_DLY+1
// clocks later and averages the depth over 2^LOG_TRIALS trials.
module gf180mcu_osu_sc_gp9t3v3__dlymon
  import gf180mcu_osu_sc_gp9t3v3__dlymon_pkg::*;
#(
  parameter int NTAPS      = 32,
  parameter int LOG_TRIALS = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CAP_DLY    = 1,
  parameter int POL_ALT    = 1,
  localparam int CW        = calc_cw(NTAPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [NTAPS-1:0] TAP,
  output logic             LAUNCH,
  output logic             BUSY,
  output logic             DONE,
  output logic [CW-1:0]    CODE,
  output logic [CW-1:0]    AVG,
  output logic             ERR
);

  localparam int AW = CW + LOG_TRIALS;
  localparam int TW = (LOG_TRIALS > 0) ? LOG_TRIALS : 1;
  localparam logic [TW-1:0] TRIAL_LAST  = TW'((1 << LOG_TRIALS) - 1);
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0]    FIRE_LAST   = 8'((CAP_DLY > 0) ? CAP_DLY - 1 : 0);
  localparam logic [MAX_TAPS-1:0] MASK_ALL = alt_mask(NTAPS);
  localparam logic [NTAPS-1:0]    TAP_MASK = (POL_ALT != 0) ? MASK_ALL[NTAPS-1:0] : '0;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TW-1:0]   trial_q, trial_d;
  logic [AW-1:0]   acc_q, acc_d, acc_sum;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   avg_q, avg_d;
  logic            err_q, err_d;

  logic [NTAPS-1:0] tap_norm;
  logic [CW-1:0]    cap_code;
  logic             cap_bubble;

  assign tap_norm = TAP ^ TAP_MASK;

  gf180mcu_osu_sc_gp9t3v3__therm2bin #(
    .NTAPS (NTAPS),
    .CW    (CW)
  ) u_therm2bin (
    .therm_i  (tap_norm),
    .code_o   (cap_code),
    .bubble_o (cap_bubble)
  );

  assign acc_sum = acc_q + AW'(cap_code);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trial_d = trial_q;
    acc_d   = acc_q;
    code_d  = code_q;
    avg_d   = avg_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_PRESET;
          cnt_d   = '0;
          trial_d = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      ST_PRESET: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = (CAP_DLY == 0) ? ST_CAPT : ST_FIRE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FIRE: begin
        if (cnt_q == FIRE_LAST) begin
          cnt_d   = '0;
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CAPT: begin
        code_d = cap_code;
        err_d  = err_q | cap_bubble;
        acc_d  = acc_sum;
        // AVG is loaded on entry to FIN so it is already valid while DONE is high.
        if (trial_q == TRIAL_LAST) begin
          state_d = ST_FIN;
          avg_d   = CW'(acc_sum >> LOG_TRIALS);
        end else begin
          trial_d = trial_q + TW'(1);
          state_d = ST_PRESET;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      trial_q <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      avg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trial_q <= trial_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      avg_q   <= avg_d;
      err_q   <= err_d;
    end
  end

  assign LAUNCH = (state_q == ST_FIRE) || (state_q == ST_CAPT);
  assign BUSY   = (state_q == ST_PRESET) || (state_q == ST_FIRE) || (state_q == ST_CAPT);
  assign DONE   = (state_q == ST_FIN);
  assign CODE   = code_q;
  assign AVG    = avg_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp9t3v3__dlymon.sv
// Bench for the delay monitor: timeline-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_gf180mcu_osu_sc_gp9t3v3__dlymon;

  localparam int NTAPS = 8, LOG_TRIALS = 2, SETTLE_CYC = 2, CAP_DLY = 1, POL_ALT = 1;
  localparam int CW  = 4;
  localparam int L   = SETTLE_CYC + CAP_DLY + 1;
  localparam int T   = 1 << LOG_TRIALS;
  localparam int TOT = L * T;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic [NTAPS-1:0] TAP;
  logic LAUNCH, BUSY, DONE, ERR;
  logic [CW-1:0] CODE, AVG;

  gf180mcu_osu_sc_gp9t3v3__dlymon #(
    .NTAPS(NTAPS), .LOG_TRIALS(LOG_TRIALS), .SETTLE_CYC(SETTLE_CYC),
    .CAP_DLY(CAP_DLY), .POL_ALT(POL_ALT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .TAP(TAP), .LAUNCH(LAUNCH),
    .BUSY(BUSY), .DONE(DONE), .CODE(CODE), .AVG(AVG), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  // Model: m_t = 0 idle, 1..TOT inside the trials, TOT+1 the done cycle.
  int m_t = 0;
  int m_sum = 0;
  int m_code = 0;
  int m_avg = 0;
  bit m_err = 1'b0;
  bit armed = 1'b0;
  int done_cnt = 0;
  logic [7:0] tap_table [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (%h) required %0d", nm, act, act, exp);
    end
  endtask

  function automatic int norm_code(input logic [7:0] tap, output bit bub);
    logic [7:0] n;
    int c;
    n = tap ^ 8'hAA;
    c = 0;
    while (c < 8 && n[c]) c++;
    bub = (c < 8) && ((n >> c) != 0);
    return c;
  endfunction

  always @(posedge CLK) begin
    bit b;
    int c;
    cyc = cyc + 1;
    if (RST) begin
      m_t = 0; m_sum = 0; m_code = 0; m_avg = 0; m_err = 1'b0; armed = 1'b1;
    end else if (m_t == 0) begin
      if (START) begin
        m_t = 1; m_sum = 0; m_err = 1'b0;
      end
    end else if (m_t <= TOT) begin
      if ((m_t - 1) % L == L - 1) begin
        c = norm_code(TAP, b);
        m_code = c;
        m_sum += c;
        m_err = m_err | b;
        if (m_t == TOT) m_avg = m_sum >> LOG_TRIALS;
      end
      m_t++;
    end else begin
      m_t = 0;
    end
  end

  always @(negedge CLK) begin
    bit in_trial;
    in_trial = (m_t >= 1) && (m_t <= TOT);
    if (armed) begin
      chk("launch", LAUNCH, (in_trial && ((m_t - 1) % L) >= SETTLE_CYC) ? 1 : 0);
      chk("busy", BUSY, in_trial ? 1 : 0);
      chk("done", DONE, (m_t == TOT + 1) ? 1 : 0);
      chk("code", CODE, m_code);
      chk("avg", AVG, m_avg);
      chk("err", ERR, m_err);
      if (DONE === 1'b1) done_cnt++;
    end
    TAP = tap_table[in_trial ? (m_t - 1) / L : 0];
  end

  task automatic wait_done();
    int n = 0;
    while (DONE !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: DONE=%b after %0d cycles, required 1", DONE, n);
    end
  endtask

  task automatic measure(input logic [7:0] t0, t1, t2, t3, output int lat, output logic e);
    int sc;
    tap_table[0] = t0; tap_table[1] = t1; tap_table[2] = t2; tap_table[3] = t3;
    START = 1'b1;
    sc = cyc;
    @(negedge CLK);
    START = 1'b0;
    e = ERR;
    wait_done();
    lat = cyc - sc;
  endtask

  task automatic wait_mt(input int target);
    int n = 0;
    while (m_t != target && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("wait_model_point", m_t, target);
  endtask

  initial begin
    int lat, d0;
    logic e;
    tap_table = '{default: 8'hA5};
    repeat (3) @(negedge CLK);
    chk("rst_launch", LAUNCH, 0); chk("rst_busy", BUSY, 0); chk("rst_done", DONE, 0);
    chk("rst_code", CODE, 0); chk("rst_avg", AVG, 0); chk("rst_err", ERR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Constant pattern: every trial gives 4 stages.
    measure(8'hA5, 8'hA5, 8'hA5, 8'hA5, lat, e);
    chk("s1_latency", lat, 17); chk("s1_avg", AVG, 4); chk("s1_code", CODE, 4); chk("s1_err", ERR, 0);
    @(negedge CLK);

    // Codes 4,4,5,6 -> sum 19 -> average 4.
    measure(8'hA5, 8'hA5, 8'hB5, 8'h95, lat, e);
    chk("s2_avg", AVG, 4); chk("s2_code", CODE, 6); chk("s2_err", ERR, 0);
    @(negedge CLK);

    // Reset during FIRE of the third trial.
    tap_table = '{default: 8'hA5};
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_mt(2 * L + SETTLE_CYC + 1);
    chk("s5_fire_launch", LAUNCH, 1);
    d0 = done_cnt;
    RST = 1'b1;
    @(negedge CLK);
    chk("s5_launch", LAUNCH, 0); chk("s5_busy", BUSY, 0); chk("s5_avg", AVG, 0); chk("s5_done", DONE, 0);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("s5_no_done", done_cnt - d0, 0);
    measure(8'hA5, 8'hA5, 8'hA5, 8'hA5, lat, e);
    chk("s5_clean_avg", AVG, 4); chk("s5_clean_latency", lat, 17);
    @(negedge CLK);

    // Bubble in trial 2: codes 4,2,4,4 -> sum 14 -> average 3.
    measure(8'hA5, 8'hA1, 8'hA5, 8'hA5, lat, e);
    chk("s3_err", ERR, 1); chk("s3_avg", AVG, 3); chk("s3_code", CODE, 4);
    @(negedge CLK);

    // Full and empty chains.
    measure(8'h55, 8'h55, 8'h55, 8'h55, lat, e);
    chk("s3_err_clear", e, 0); chk("s4_full_code", CODE, 8); chk("s4_full_avg", AVG, 8);
    @(negedge CLK);
    measure(8'hAA, 8'hAA, 8'hAA, 8'hAA, lat, e);
    chk("s4_empty_code", CODE, 0); chk("s4_empty_avg", AVG, 0); chk("s4_empty_err", ERR, 0);
    @(negedge CLK);

    // START while busy and during the done cycle is ignored.
    tap_table = '{default: 8'hA5};
    d0 = done_cnt;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_mt(6);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    chk("s6_one_done", done_cnt - d0, 1);
    chk("s6_idle_busy", BUSY, 0);

    // START held from the done cycle into idle starts a new measurement.
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done();
    START = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b0;
    chk("s6_restart_busy", BUSY, 1);
    wait_done();
    chk("s6_restart_avg", AVG, 4);
    @(negedge CLK);

    // Random tap patterns and idle gaps; the per-cycle model does the checking.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      measure(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), lat, e);
      chk("rnd_latency", lat, 17);
      @(negedge CLK);
    end

    repeat (2) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
